// File: rtl/tcam_lpm.sv
// Longest-prefix-match route table: DEPTH entries searched in parallel, result two cycles
// after acceptance, plus a sequential clear engine that walks the table invalidating entries.
module tcam_lpm #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned IFW    = 4,
   localparam int unsigned IW    = $clog2(DEPTH),
   localparam int unsigned LW    = $clog2(AW) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_en,
   input  logic [IW-1:0]  wr_index,
   input  logic           wr_valid,
   input  logic [AW-1:0]  wr_prefix,
   input  logic [LW-1:0]  wr_len,
   input  logic [AW-1:0]  wr_nexthop,
   input  logic [IFW-1:0] wr_if,
   input  logic           clr_start,
   output logic           clr_busy,
   input  logic           lk_valid,
   output logic           lk_ready,
   input  logic [AW-1:0]  lk_addr,
   output logic           res_valid,
   output logic           res_hit,
   output logic [IW-1:0]  res_index,
   output logic [LW-1:0]  res_len,
   output logic [AW-1:0]  res_nexthop,
   output logic [IFW-1:0] res_if
);

   typedef enum logic [1:0] {StIdle, StClear, StDrain} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;

   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    prefix_q  [DEPTH];
   logic [LW-1:0]    len_q     [DEPTH];
   logic [AW-1:0]    nexthop_q [DEPTH];
   logic [IFW-1:0]   if_q      [DEPTH];

   logic          wr_fire, lk_fire;
   logic [LW-1:0] wr_len_sat;

   assign lk_ready   = (state_q == StIdle);
   assign clr_busy   = (state_q != StIdle);
   assign wr_fire    = wr_en & lk_ready;
   assign lk_fire    = lk_valid & lk_ready;
   assign wr_len_sat = (wr_len > LW'(AW)) ? LW'(AW) : wr_len;

   // Clear FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (clr_start) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         StClear: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(DEPTH - 1)) state_d = StDrain;
         end
         StDrain: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == StClear) begin
            valid_q[cnt_q] <= 1'b0;
         end else if (wr_fire) begin
            valid_q[wr_index] <= wr_valid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         prefix_q[wr_index]  <= wr_prefix;
         len_q[wr_index]     <= wr_len_sat;
         nexthop_q[wr_index] <= wr_nexthop;
         if_q[wr_index]      <= wr_if;
      end
   end

   // Stage 1: per-entry match against the contents present before this edge's write
   logic [DEPTH-1:0] match;

   always_comb begin
      match = '0;
      for (int e = 0; e < int'(DEPTH); e++) begin
         match[e] = valid_q[e] &&
                    (((lk_addr ^ prefix_q[e]) & ~({AW{1'b1}} >> len_q[e])) == '0);
      end
   end

   logic             s1_valid_q;
   logic [DEPTH-1:0] s1_match_q;

   // Old contents of the entry overwritten on the acceptance edge, so the reduction one
   // cycle later still sees the table exactly as the match vector did.
   logic             sh_valid_q;
   logic [IW-1:0]    sh_index_q;
   logic [LW-1:0]    sh_len_q;
   logic [AW-1:0]    sh_nexthop_q;
   logic [IFW-1:0]   sh_if_q;

   // Stage 2: reduction, largest length first, lowest index on ties
   logic           red_hit;
   logic [IW-1:0]  red_index;
   logic [LW-1:0]  red_len;
   logic [AW-1:0]  red_nexthop;
   logic [IFW-1:0] red_if;

   always_comb begin
      logic           e_sh;
      logic [LW-1:0]  e_len;
      logic [AW-1:0]  e_nexthop;
      logic [IFW-1:0] e_if;
      red_hit     = 1'b0;
      red_index   = '0;
      red_len     = '0;
      red_nexthop = '0;
      red_if      = '0;
      e_sh        = 1'b0;
      e_len       = '0;
      e_nexthop   = '0;
      e_if        = '0;
      for (int e = 0; e < int'(DEPTH); e++) begin
         e_sh      = sh_valid_q && (sh_index_q == IW'(e));
         e_len     = e_sh ? sh_len_q     : len_q[e];
         e_nexthop = e_sh ? sh_nexthop_q : nexthop_q[e];
         e_if      = e_sh ? sh_if_q      : if_q[e];
         if (s1_match_q[e] && (!red_hit || e_len > red_len)) begin
            red_hit     = 1'b1;
            red_index   = IW'(e);
            red_len     = e_len;
            red_nexthop = e_nexthop;
            red_if      = e_if;
         end
      end
   end

   logic           s2_valid_q;
   logic           s2_hit_q;
   logic [IW-1:0]  s2_index_q;
   logic [LW-1:0]  s2_len_q;
   logic [AW-1:0]  s2_nexthop_q;
   logic [IFW-1:0] s2_if_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_match_q   <= '0;
         sh_valid_q   <= 1'b0;
         sh_index_q   <= '0;
         sh_len_q     <= '0;
         sh_nexthop_q <= '0;
         sh_if_q      <= '0;
         s2_valid_q   <= 1'b0;
         s2_hit_q     <= 1'b0;
         s2_index_q   <= '0;
         s2_len_q     <= '0;
         s2_nexthop_q <= '0;
         s2_if_q      <= '0;
         res_valid    <= 1'b0;
         res_hit      <= 1'b0;
         res_index    <= '0;
         res_len      <= '0;
         res_nexthop  <= '0;
         res_if       <= '0;
      end else begin
         s1_valid_q   <= lk_fire;
         if (lk_fire) s1_match_q <= match;
         sh_valid_q   <= wr_fire;
         sh_index_q   <= wr_index;
         sh_len_q     <= len_q[wr_index];
         sh_nexthop_q <= nexthop_q[wr_index];
         sh_if_q      <= if_q[wr_index];

         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_hit_q     <= red_hit;
            s2_index_q   <= red_index;
            s2_len_q     <= red_len;
            s2_nexthop_q <= red_nexthop;
            s2_if_q      <= red_if;
         end

         res_valid <= s2_valid_q;
         if (s2_valid_q) begin
            res_hit     <= s2_hit_q;
            res_index   <= s2_index_q;
            res_len     <= s2_len_q;
            res_nexthop <= s2_nexthop_q;
            res_if      <= s2_if_q;
         end
      end
   end

endmodule

// File: tb/tb_tcam_lpm.sv
// Self-checking bench for tcam_lpm: directed route scenarios plus randomized traffic scored
// against an array-based longest-prefix-match model.
module tb_tcam_lpm;
   localparam int AW = 32, DEPTH = 32, IFW = 4, IW = 5, LW = 6;

   logic           clk = 1'b0, rst = 1'b1;
   logic           wr_en = 0, wr_valid = 0, clr_start = 0, lk_valid = 0;
   logic [IW-1:0]  wr_index = '0;
   logic [AW-1:0]  wr_prefix = '0, wr_nexthop = '0, lk_addr = '0;
   logic [LW-1:0]  wr_len = '0;
   logic [IFW-1:0] wr_if = '0;
   logic           clr_busy, lk_ready, res_valid, res_hit;
   logic [IW-1:0]  res_index;
   logic [LW-1:0]  res_len;
   logic [AW-1:0]  res_nexthop;
   logic [IFW-1:0] res_if;

   tcam_lpm #(.AW(AW), .DEPTH(DEPTH), .IFW(IFW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_index(wr_index), .wr_valid(wr_valid),
      .wr_prefix(wr_prefix), .wr_len(wr_len), .wr_nexthop(wr_nexthop), .wr_if(wr_if),
      .clr_start(clr_start), .clr_busy(clr_busy), .lk_valid(lk_valid), .lk_ready(lk_ready),
      .lk_addr(lk_addr), .res_valid(res_valid), .res_hit(res_hit), .res_index(res_index),
      .res_len(res_len), .res_nexthop(res_nexthop), .res_if(res_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          hit;
      int          idx;
      int          len;
      logic [31:0] nh;
      logic [3:0]  ifc;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   bit          m_valid  [DEPTH];
   logic [31:0] m_prefix [DEPTH];
   int          m_len    [DEPTH];
   logic [31:0] m_nh     [DEPTH];
   logic [3:0]  m_if     [DEPTH];
   int          cyc = 0, n_cmp = 0, n_fail = 0;

   // Reference: try lengths from longest down; first matching index at a length wins.
   function automatic exp_t model_lookup(logic [31:0] a);
      exp_t r;
      logic [63:0] aa, pp;
      r = '{default: 0};
      for (int l = 32; l >= 0 && !r.hit; l--) begin
         aa = {32'b0, a} >> (32 - l);
         for (int e = 0; e < DEPTH && !r.hit; e++) begin
            pp = {32'b0, m_prefix[e]} >> (32 - l);
            if (m_valid[e] && m_len[e] == l && aa == pp) begin
               r.hit = 1; r.idx = e; r.len = l; r.nh = m_nh[e]; r.ifc = m_if[e];
            end
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      foreach (m_valid[e]) m_valid[e] = 0;
      exp_q.delete();
   endtask

   task automatic step();
      exp_t r;
      if (lk_valid && lk_ready) begin
         r = model_lookup(lk_addr);
         r.cyc = cyc + 1;
         exp_q.push_back(r);
      end
      if (wr_en && !clr_busy) begin
         m_valid[wr_index]  = wr_valid;
         m_prefix[wr_index] = wr_prefix;
         m_len[wr_index]    = (wr_len > 32) ? 32 : int'(wr_len);
         m_nh[wr_index]     = wr_nexthop;
         m_if[wr_index]     = wr_if;
      end
      if (clr_start && !clr_busy) foreach (m_valid[e]) m_valid[e] = 0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_write(int idx, bit v, logic [31:0] p, int len, logic [31:0] nh,
                           logic [3:0] ifc);
      wr_en = 1; wr_index = 5'(idx); wr_valid = v; wr_prefix = p; wr_len = 6'(len);
      wr_nexthop = nh; wr_if = ifc;
      step();
      wr_en = 0;
   endtask

   // Issues one lookup and reports what came back; g.cyc is the latency or -1 on timeout.
   task automatic run_lookup(logic [31:0] a, output exp_t g);
      g = '{default: 0};
      g.cyc = -1;
      lk_valid = 1; lk_addr = a;
      step();
      lk_valid = 0;
      for (int k = 0; k < 8; k++) begin
         if (res_valid) begin
            g.hit = res_hit; g.idx = int'(res_index); g.len = int'(res_len);
            g.nh = res_nexthop; g.ifc = res_if; g.cyc = k;
            break;
         end
         step();
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({clr_busy, lk_ready, res_valid, res_hit} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_status: busy/ready/valid/hit=%b, need 0100",
                  {clr_busy, lk_ready, res_valid, res_hit});
      end
      n_cmp++;
      if ({res_index, res_len, res_nexthop, res_if} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: idx=%0d len=%0d nh=%h if=%0d, need all 0",
                  res_index, res_len, res_nexthop, res_if);
      end
      rst = 0;
      step();
      step();
      n_cmp++;
      if ({clr_busy, lk_ready, res_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL post_reset_status: busy/ready/valid=%b, need 010",
                  {clr_busy, lk_ready, res_valid});
      end
   endtask

   task automatic test_directed();
      exp_t g;
      do_write(3, 1, 32'hC0A8_0000, 24, 32'h0A00_0001, 4'd1);
      do_write(5, 1, 32'hC0A8_0020, 27, 32'h0A00_0002, 4'd2);
      do_write(9, 1, 32'h0000_0000, 0, 32'h0A00_0003, 4'd7);
      run_lookup(32'hC0A8_0021, g);
      n_cmp++;
      if (g.cyc != 2 || !g.hit || g.idx != 5 || g.len != 27 || g.ifc !== 4'd2 ||
          g.nh !== 32'h0A00_0002) begin
         n_fail++;
         $display("FAIL lpm_27: lat=%0d hit=%0d idx=%0d len=%0d if=%0d nh=%h, need 2 1 5 27 2 0a000002",
                  g.cyc, g.hit, g.idx, g.len, g.ifc, g.nh);
      end
      run_lookup(32'hC0A8_000A, g);
      n_cmp++;
      if (g.cyc != 2 || !g.hit || g.idx != 3 || g.len != 24 || g.ifc !== 4'd1) begin
         n_fail++;
         $display("FAIL lpm_24: lat=%0d hit=%0d idx=%0d len=%0d if=%0d, need 2 1 3 24 1",
                  g.cyc, g.hit, g.idx, g.len, g.ifc);
      end
      run_lookup(32'h0A00_0002, g);
      n_cmp++;
      if (!g.hit || g.idx != 9 || g.len != 0 || g.ifc !== 4'd7) begin
         n_fail++;
         $display("FAIL default_route: hit=%0d idx=%0d len=%0d if=%0d, need 1 9 0 7",
                  g.hit, g.idx, g.len, g.ifc);
      end
      do_write(9, 0, 32'h0, 0, 32'h0, 4'd0);
      run_lookup(32'h0A00_0002, g);
      n_cmp++;
      if (g.cyc != 2 || g.hit || g.idx != 0 || g.len != 0 || g.ifc !== 4'd0 || g.nh !== '0) begin
         n_fail++;
         $display("FAIL miss_zero: lat=%0d hit=%0d idx=%0d len=%0d if=%0d nh=%h, need 2 0 0 0 0 0",
                  g.cyc, g.hit, g.idx, g.len, g.ifc, g.nh);
      end
      do_write(6, 1, 32'h0A00_0000, 8, 32'h0B00_0006, 4'd3);
      do_write(2, 1, 32'h0A00_0000, 8, 32'h0B00_0002, 4'd5);
      run_lookup(32'h0A01_0203, g);
      n_cmp++;
      if (!g.hit || g.idx != 2 || g.len != 8 || g.ifc !== 4'd5 || g.nh !== 32'h0B00_0002) begin
         n_fail++;
         $display("FAIL tie_low_index: hit=%0d idx=%0d len=%0d if=%0d, need 1 2 8 5",
                  g.hit, g.idx, g.len, g.ifc);
      end
      do_write(12, 1, 32'hAC10_0505, 40, 32'h0C00_0000, 4'd6);
      run_lookup(32'hAC10_0505, g);
      n_cmp++;
      if (!g.hit || g.idx != 12 || g.len != 32 || g.ifc !== 4'd6) begin
         n_fail++;
         $display("FAIL len_saturate: hit=%0d idx=%0d len=%0d if=%0d, need 1 12 32 6",
                  g.hit, g.idx, g.len, g.ifc);
      end
      run_lookup(32'hAC10_0504, g);
      n_cmp++;
      if (g.hit) begin
         n_fail++;
         $display("FAIL host_route_miss: hit=%0d idx=%0d, need hit=0", g.hit, g.idx);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t got[$];
      int   n_pulse = 0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         if (i < 12) begin
            lk_valid = 1;
            case (i % 4)
               0: lk_addr = 32'hC0A8_0021;
               1: lk_addr = 32'hC0A8_000A;
               2: lk_addr = 32'h0A01_0203;
               default: lk_addr = $urandom;
            endcase
            if (i == 1 || i == 2) lk_addr = 32'hC0A8_000A;
         end else begin
            lk_valid = 0;
         end
         wr_en = (i == 1);
         wr_index = 5'd3; wr_valid = 1; wr_prefix = $urandom; wr_len = 6'd0;
         wr_nexthop = 32'h0D00_0003; wr_if = 4'd4;
         step();
         wr_en = 0;
         if (res_valid) begin
            n_pulse++;
            got.push_back('{res_hit, int'(res_index), int'(res_len), res_nexthop, res_if, cyc});
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_spurious: res_valid=1 at cycle %0d, need none", cyc);
            end else begin
               e = exp_q.pop_front();
               if (cyc != e.cyc + 2 || res_hit !== e.hit || res_index !== 5'(e.idx) ||
                   res_len !== 6'(e.len) || res_nexthop !== e.nh || res_if !== e.ifc) begin
                  n_fail++;
                  $display("FAIL b2b_result: cyc=%0d hit=%0d idx=%0d len=%0d if=%0d, need cyc=%0d %0d %0d %0d %0d",
                           cyc, res_hit, res_index, res_len, res_if, e.cyc + 2, e.hit, e.idx,
                           e.len, e.ifc);
               end
            end
         end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc + 2) begin
            n_cmp++; n_fail++;
            $display("FAIL b2b_missing: no res_valid at cycle %0d, need one", cyc);
            void'(exp_q.pop_front());
         end
      end
      n_cmp++;
      if (n_pulse != 12) begin
         n_fail++;
         $display("FAIL b2b_count: %0d pulses, need 12", n_pulse);
      end
      n_cmp++;
      if (got.size() < 3 || got[1].idx != 3 || got[1].len != 24 || got[1].ifc !== 4'd1 ||
          got[2].idx != 3 || got[2].len != 0 || got[2].ifc !== 4'd4) begin
         n_fail++;
         $display("FAIL write_vs_lookup: results 2/3 not old(3,/24,if1) then new(3,/0,if4)");
      end
   endtask

   task automatic test_random();
      exp_t    e;
      int      k;
      for (int i = 0; i < 404; i++) begin
         lk_valid = (i < 400) && ($urandom_range(0, 3) != 0);
         k = $urandom_range(0, DEPTH - 1);
         lk_addr = ($urandom_range(0, 4) == 0) ? $urandom :
                   m_prefix[k] ^ ($urandom >> $urandom_range(0, 32));
         wr_en = (i < 400) && ($urandom_range(0, 3) == 0);
         wr_index = 5'($urandom_range(0, DEPTH - 1));
         wr_valid = ($urandom_range(0, 4) != 0);
         wr_prefix = $urandom[0] ? $urandom : m_prefix[k] ^ ($urandom >> 20);
         wr_len = 6'($urandom_range(0, 40));
         wr_nexthop = $urandom; wr_if = 4'($urandom);
         step();
         if (res_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_spurious: res_valid=1 at cycle %0d, need none", cyc);
            end else begin
               e = exp_q.pop_front();
               if (cyc != e.cyc + 2 || res_hit !== e.hit || res_index !== 5'(e.idx) ||
                   res_len !== 6'(e.len) || res_nexthop !== e.nh || res_if !== e.ifc) begin
                  n_fail++;
                  $display("FAIL rand_result: cyc=%0d hit=%0d idx=%0d len=%0d nh=%h if=%0d, need cyc=%0d %0d %0d %0d %h %0d",
                           cyc, res_hit, res_index, res_len, res_nexthop, res_if, e.cyc + 2,
                           e.hit, e.idx, e.len, e.nh, e.ifc);
               end
            end
         end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc + 2) begin
            n_cmp++; n_fail++;
            $display("FAIL rand_missing: no res_valid at cycle %0d, need one", cyc);
            void'(exp_q.pop_front());
         end
      end
      lk_valid = 0; wr_en = 0;
   endtask

   task automatic test_clear();
      exp_t e, g;
      int   busy = 0, ready_bad = 0, n_pulse = 0;
      for (int i = 0; i < DEPTH; i++)
         do_write(i, 1, $urandom, $urandom_range(0, 32), $urandom, 4'($urandom));
      exp_q.delete();
      lk_valid = 1; lk_addr = m_prefix[7]; clr_start = 1;
      step();
      for (int k = 0; k < 50; k++) begin
         if (res_valid) begin
            n_pulse++;
            n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '{default: 0};
            if (!e.hit || res_hit !== 1'b1 || res_index !== 5'(e.idx) ||
                res_len !== 6'(e.len) || res_if !== e.ifc) begin
               n_fail++;
               $display("FAIL clear_inflight: hit=%0d idx=%0d len=%0d, need 1 %0d %0d",
                        res_hit, res_index, res_len, e.idx, e.len);
            end
         end
         if (!clr_busy) break;
         busy++;
         if (lk_ready) ready_bad++;
         lk_valid = 1; lk_addr = $urandom;
         wr_en = $urandom[0]; wr_index = 5'($urandom); wr_valid = 1; wr_prefix = 0;
         wr_len = 0; clr_start = $urandom[0];
         step();
      end
      lk_valid = 0; wr_en = 0; clr_start = 0;
      n_cmp++;
      if (busy != DEPTH + 1 || ready_bad != 0) begin
         n_fail++;
         $display("FAIL clear_duration: busy=%0d ready_high=%0d, need %0d and 0", busy,
                  ready_bad, DEPTH + 1);
      end
      n_cmp++;
      if (n_pulse != 1) begin
         n_fail++;
         $display("FAIL clear_inflight_count: %0d results, need 1", n_pulse);
      end
      for (int i = 0; i < 6; i++) begin
         run_lookup((i == 0) ? m_prefix[0] : $urandom, g);
         n_cmp++;
         if (g.cyc != 2 || g.hit || g.idx != 0 || g.len != 0 || g.nh !== '0) begin
            n_fail++;
            $display("FAIL clear_empty: lat=%0d hit=%0d idx=%0d len=%0d, need 2 0 0 0",
                     g.cyc, g.hit, g.idx, g.len);
         end
      end
   endtask

   task automatic test_reset_abort();
      exp_t g;
      int   bad = 0;
      for (int i = 20; i < 24; i++) do_write(i, 1, $urandom, 0, $urandom, 4'd9);
      clr_start = 1;
      step();
      clr_start = 0;
      repeat (4) step();
      #2 rst = 1;
      #1;
      n_cmp++;
      if (clr_busy !== 1'b0 || lk_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_clear: busy=%0d ready=%0d, need 0 1", clr_busy, lk_ready);
      end
      model_reset();
      step();
      rst = 0;
      step();
      run_lookup($urandom, g);
      n_cmp++;
      if (g.cyc != 2 || g.hit) begin
         n_fail++;
         $display("FAIL reset_table_empty: lat=%0d hit=%0d, need 2 0", g.cyc, g.hit);
      end
      do_write(25, 1, 32'h0, 0, 32'h1, 4'd1);
      lk_valid = 1; lk_addr = $urandom;
      step();
      lk_valid = 0;
      #2 rst = 1;
      model_reset();
      for (int k = 0; k < 5; k++) begin
         if (res_valid) bad++;
         step();
         rst = 0;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL reset_mid_lookup: %0d result strobes, need 0", bad);
      end
   endtask

   initial begin
      foreach (m_prefix[e]) begin
         m_prefix[e] = '0; m_len[e] = 0; m_nh[e] = '0; m_if[e] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_clear();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
